// File: rtl/axil_memory_arbiter_pkg.sv
// axil_memory_arbiter_pkg: shared FSM state, port index and AXI response encodings for the memory arbiter
package axil_memory_arbiter_pkg;
    typedef enum logic [2:0] {
        ARB_IDLE,
        ARB_RD_ADDR,
        ARB_RD_RESP,
        ARB_WR_REQ,
        ARB_WR_RESP
    } arb_state_t;
    localparam int PORT_INSTR = 0;
    localparam int PORT_DATA = 1;
    localparam logic [1:0] RESP_OKAY = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;
endpackage

// File: rtl/round_robin_arbiter_2.sv
// round_robin_arbiter_2: two-way round-robin pick; ptr = 0 favours instr, 1 favours data on contention
module round_robin_arbiter_2
    import axil_memory_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] grant,
    output logic       next_ptr
);
    always_comb begin
        grant = &req ? (ptr ? 2'b10 : 2'b01) : req;
        next_ptr = |grant ? grant[PORT_INSTR] : ptr;
    end
endmodule

// File: rtl/axil_memory_arbiter.sv
// axil_memory_arbiter: serialises instr/data AXI-Lite transactions onto one memory slave, round-robin
module axil_memory_arbiter
    import axil_memory_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  i_Clock,
    input  logic                  i_Reset_N,
    input  logic [ADDR_WIDTH-1:0] s_instr_axil_araddr,
    input  logic [ADDR_WIDTH-1:0] s_instr_axil_awaddr,
    input  logic [DATA_WIDTH-1:0] s_instr_axil_wdata,
    input  logic [STRB_WIDTH-1:0] s_instr_axil_wstrb,
    input  logic                  s_instr_axil_arvalid,
    input  logic                  s_instr_axil_awvalid,
    input  logic                  s_instr_axil_wvalid,
    input  logic                  s_instr_axil_rready,
    input  logic                  s_instr_axil_bready,
    output logic                  s_instr_axil_arready,
    output logic                  s_instr_axil_awready,
    output logic                  s_instr_axil_wready,
    output logic                  s_instr_axil_rvalid,
    output logic                  s_instr_axil_bvalid,
    output logic [DATA_WIDTH-1:0] s_instr_axil_rdata,
    output logic [1:0]            s_instr_axil_bresp,
    input  logic [ADDR_WIDTH-1:0] s_data_axil_araddr,
    input  logic [ADDR_WIDTH-1:0] s_data_axil_awaddr,
    input  logic [DATA_WIDTH-1:0] s_data_axil_wdata,
    input  logic [STRB_WIDTH-1:0] s_data_axil_wstrb,
    input  logic                  s_data_axil_arvalid,
    input  logic                  s_data_axil_awvalid,
    input  logic                  s_data_axil_wvalid,
    input  logic                  s_data_axil_rready,
    input  logic                  s_data_axil_bready,
    output logic                  s_data_axil_arready,
    output logic                  s_data_axil_awready,
    output logic                  s_data_axil_wready,
    output logic                  s_data_axil_rvalid,
    output logic                  s_data_axil_bvalid,
    output logic [DATA_WIDTH-1:0] s_data_axil_rdata,
    output logic [1:0]            s_data_axil_bresp,
    output logic [ADDR_WIDTH-1:0] m_axil_araddr,
    output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
    output logic [DATA_WIDTH-1:0] m_axil_wdata,
    output logic [STRB_WIDTH-1:0] m_axil_wstrb,
    output logic                  m_axil_arvalid,
    output logic                  m_axil_awvalid,
    output logic                  m_axil_wvalid,
    output logic                  m_axil_rready,
    output logic                  m_axil_bready,
    input  logic                  m_axil_arready,
    input  logic                  m_axil_awready,
    input  logic                  m_axil_wready,
    input  logic                  m_axil_rvalid,
    input  logic                  m_axil_bvalid,
    input  logic [DATA_WIDTH-1:0] m_axil_rdata,
    input  logic [1:0]            m_axil_bresp,
    output logic [1:0]            o_Grant
);
    arb_state_t state, state_next;
    logic [1:0] grant, rr_grant, req;
    logic ptr, rr_next_ptr, is_write, aw_done, w_done;
    logic sel, any, rd_addr, rd_resp, wr_req, wr_resp, aw_fire, w_fire;
    logic gi, gd;
    assign req = {s_data_axil_arvalid | s_data_axil_awvalid, s_instr_axil_arvalid | s_instr_axil_awvalid};
    assign is_write = rr_grant[PORT_DATA] ? s_data_axil_awvalid : s_instr_axil_awvalid;
    assign o_Grant = grant;
    round_robin_arbiter_2 u_rr (
        .req      (req),
        .ptr      (ptr),
        .grant    (rr_grant),
        .next_ptr (rr_next_ptr)
    );
    always_comb begin
        sel = grant[PORT_DATA];
        any = |grant;
        gi = grant[PORT_INSTR];
        gd = grant[PORT_DATA];
        rd_addr = state == ARB_RD_ADDR;
        rd_resp = state == ARB_RD_RESP;
        wr_req = state == ARB_WR_REQ;
        wr_resp = state == ARB_WR_RESP;
        m_axil_araddr = any ? (sel ? s_data_axil_araddr : s_instr_axil_araddr) : '0;
        m_axil_awaddr = any ? (sel ? s_data_axil_awaddr : s_instr_axil_awaddr) : '0;
        m_axil_wdata = any ? (sel ? s_data_axil_wdata : s_instr_axil_wdata) : '0;
        m_axil_wstrb = any ? (sel ? s_data_axil_wstrb : s_instr_axil_wstrb) : '0;
        m_axil_arvalid = rd_addr & (sel ? s_data_axil_arvalid : s_instr_axil_arvalid);
        m_axil_awvalid = wr_req & ~aw_done & (sel ? s_data_axil_awvalid : s_instr_axil_awvalid);
        m_axil_wvalid = wr_req & ~w_done & (sel ? s_data_axil_wvalid : s_instr_axil_wvalid);
        m_axil_rready = rd_resp & (sel ? s_data_axil_rready : s_instr_axil_rready);
        m_axil_bready = wr_resp & (sel ? s_data_axil_bready : s_instr_axil_bready);
        aw_fire = m_axil_awvalid & m_axil_awready;
        w_fire = m_axil_wvalid & m_axil_wready;
        s_instr_axil_arready = gi & rd_addr & m_axil_arready;
        s_instr_axil_awready = gi & wr_req & ~aw_done & m_axil_awready;
        s_instr_axil_wready = gi & wr_req & ~w_done & m_axil_wready;
        s_instr_axil_rvalid = gi & rd_resp & m_axil_rvalid;
        s_instr_axil_bvalid = gi & wr_resp & m_axil_bvalid;
        s_instr_axil_rdata = gi ? m_axil_rdata : '0;
        s_instr_axil_bresp = gi ? m_axil_bresp : RESP_OKAY;
        s_data_axil_arready = gd & rd_addr & m_axil_arready;
        s_data_axil_awready = gd & wr_req & ~aw_done & m_axil_awready;
        s_data_axil_wready = gd & wr_req & ~w_done & m_axil_wready;
        s_data_axil_rvalid = gd & rd_resp & m_axil_rvalid;
        s_data_axil_bvalid = gd & wr_resp & m_axil_bvalid;
        s_data_axil_rdata = gd ? m_axil_rdata : '0;
        s_data_axil_bresp = gd ? m_axil_bresp : RESP_OKAY;
    end
    always_comb begin
        state_next = state;
        unique case (state)
            ARB_IDLE:    state_next = |rr_grant ? (is_write ? ARB_WR_REQ : ARB_RD_ADDR) : ARB_IDLE;
            ARB_RD_ADDR: state_next = (m_axil_arvalid & m_axil_arready) ? ARB_RD_RESP : ARB_RD_ADDR;
            ARB_RD_RESP: state_next = (m_axil_rvalid & m_axil_rready) ? ARB_IDLE : ARB_RD_RESP;
            ARB_WR_REQ:  state_next = ((aw_done | aw_fire) & (w_done | w_fire)) ? ARB_WR_RESP : ARB_WR_REQ;
            ARB_WR_RESP: state_next = (m_axil_bvalid & m_axil_bready) ? ARB_IDLE : ARB_WR_RESP;
            default:     state_next = ARB_IDLE;
        endcase
    end
    always_ff @(posedge i_Clock) begin
        if (!i_Reset_N) state <= ARB_IDLE;
        else state <= state_next;
    end
    always_ff @(posedge i_Clock) begin
        if (!i_Reset_N) begin
            grant <= '0;
            ptr <= 1'(PORT_INSTR);
            aw_done <= 1'b0;
            w_done <= 1'b0;
        end else begin
            if (state == ARB_IDLE && |rr_grant) begin
                grant <= rr_grant;
                ptr <= rr_next_ptr;
            end else if (state_next == ARB_IDLE) begin
                grant <= '0;
            end
            aw_done <= wr_req & (state_next == ARB_WR_REQ) & (aw_done | aw_fire);
            w_done <= wr_req & (state_next == ARB_WR_REQ) & (w_done | w_fire);
        end
    end
    // Upstream masters may not withdraw a valid before its handshake
    a_ar_hold: assert property (@(posedge i_Clock) disable iff (!i_Reset_N)
        (m_axil_arvalid && !m_axil_arready) |=> m_axil_arvalid);
    a_aw_hold: assert property (@(posedge i_Clock) disable iff (!i_Reset_N)
        (m_axil_awvalid && !m_axil_awready) |=> m_axil_awvalid);
    a_w_hold: assert property (@(posedge i_Clock) disable iff (!i_Reset_N)
        (m_axil_wvalid && !m_axil_wready) |=> m_axil_wvalid);
endmodule

// File: tb/tb_axil_memory_arbiter.sv
// tb_axil_memory_arbiter: directed vectors for the two-port AXI-Lite memory arbiter
module tb_axil_memory_arbiter;
    logic        i_Clock = 1'b0;
    logic        i_Reset_N;
    logic [31:0] s_instr_axil_araddr, s_instr_axil_awaddr, s_instr_axil_wdata, s_instr_axil_rdata;
    logic [3:0]  s_instr_axil_wstrb;
    logic        s_instr_axil_arvalid, s_instr_axil_awvalid, s_instr_axil_wvalid, s_instr_axil_rready, s_instr_axil_bready;
    logic        s_instr_axil_arready, s_instr_axil_awready, s_instr_axil_wready, s_instr_axil_rvalid, s_instr_axil_bvalid;
    logic [1:0]  s_instr_axil_bresp;
    logic [31:0] s_data_axil_araddr, s_data_axil_awaddr, s_data_axil_wdata, s_data_axil_rdata;
    logic [3:0]  s_data_axil_wstrb;
    logic        s_data_axil_arvalid, s_data_axil_awvalid, s_data_axil_wvalid, s_data_axil_rready, s_data_axil_bready;
    logic        s_data_axil_arready, s_data_axil_awready, s_data_axil_wready, s_data_axil_rvalid, s_data_axil_bvalid;
    logic [1:0]  s_data_axil_bresp;
    logic [31:0] m_axil_araddr, m_axil_awaddr, m_axil_wdata, m_axil_rdata;
    logic [3:0]  m_axil_wstrb;
    logic        m_axil_arvalid, m_axil_awvalid, m_axil_wvalid, m_axil_rready, m_axil_bready;
    logic        m_axil_arready, m_axil_awready, m_axil_wready, m_axil_rvalid, m_axil_bvalid;
    logic [1:0]  m_axil_bresp;
    logic [1:0]  o_Grant;
    int checks = 0;
    int errors = 0;

    always #5 i_Clock = ~i_Clock;

    axil_memory_arbiter dut (
        .i_Clock(i_Clock), .i_Reset_N(i_Reset_N),
        .s_instr_axil_araddr(s_instr_axil_araddr), .s_instr_axil_awaddr(s_instr_axil_awaddr),
        .s_instr_axil_wdata(s_instr_axil_wdata), .s_instr_axil_wstrb(s_instr_axil_wstrb),
        .s_instr_axil_arvalid(s_instr_axil_arvalid), .s_instr_axil_awvalid(s_instr_axil_awvalid),
        .s_instr_axil_wvalid(s_instr_axil_wvalid), .s_instr_axil_rready(s_instr_axil_rready),
        .s_instr_axil_bready(s_instr_axil_bready), .s_instr_axil_arready(s_instr_axil_arready),
        .s_instr_axil_awready(s_instr_axil_awready), .s_instr_axil_wready(s_instr_axil_wready),
        .s_instr_axil_rvalid(s_instr_axil_rvalid), .s_instr_axil_bvalid(s_instr_axil_bvalid),
        .s_instr_axil_rdata(s_instr_axil_rdata), .s_instr_axil_bresp(s_instr_axil_bresp),
        .s_data_axil_araddr(s_data_axil_araddr), .s_data_axil_awaddr(s_data_axil_awaddr),
        .s_data_axil_wdata(s_data_axil_wdata), .s_data_axil_wstrb(s_data_axil_wstrb),
        .s_data_axil_arvalid(s_data_axil_arvalid), .s_data_axil_awvalid(s_data_axil_awvalid),
        .s_data_axil_wvalid(s_data_axil_wvalid), .s_data_axil_rready(s_data_axil_rready),
        .s_data_axil_bready(s_data_axil_bready), .s_data_axil_arready(s_data_axil_arready),
        .s_data_axil_awready(s_data_axil_awready), .s_data_axil_wready(s_data_axil_wready),
        .s_data_axil_rvalid(s_data_axil_rvalid), .s_data_axil_bvalid(s_data_axil_bvalid),
        .s_data_axil_rdata(s_data_axil_rdata), .s_data_axil_bresp(s_data_axil_bresp),
        .m_axil_araddr(m_axil_araddr), .m_axil_awaddr(m_axil_awaddr),
        .m_axil_wdata(m_axil_wdata), .m_axil_wstrb(m_axil_wstrb),
        .m_axil_arvalid(m_axil_arvalid), .m_axil_awvalid(m_axil_awvalid),
        .m_axil_wvalid(m_axil_wvalid), .m_axil_rready(m_axil_rready),
        .m_axil_bready(m_axil_bready), .m_axil_arready(m_axil_arready),
        .m_axil_awready(m_axil_awready), .m_axil_wready(m_axil_wready),
        .m_axil_rvalid(m_axil_rvalid), .m_axil_bvalid(m_axil_bvalid),
        .m_axil_rdata(m_axil_rdata), .m_axil_bresp(m_axil_bresp),
        .o_Grant(o_Grant)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge i_Clock);
        #1;
    endtask

    task automatic clear_inputs();
        {s_instr_axil_araddr, s_instr_axil_awaddr, s_instr_axil_wdata, s_instr_axil_wstrb} = '0;
        {s_instr_axil_arvalid, s_instr_axil_awvalid, s_instr_axil_wvalid, s_instr_axil_rready, s_instr_axil_bready} = '0;
        {s_data_axil_araddr, s_data_axil_awaddr, s_data_axil_wdata, s_data_axil_wstrb} = '0;
        {s_data_axil_arvalid, s_data_axil_awvalid, s_data_axil_wvalid, s_data_axil_rready, s_data_axil_bready} = '0;
        {m_axil_arready, m_axil_awready, m_axil_wready, m_axil_rvalid, m_axil_bvalid} = '0;
        m_axil_rdata = '0;
        m_axil_bresp = '0;
    endtask

    task automatic reset_pulse();
        i_Reset_N = 1'b0;
        step();
        i_Reset_N = 1'b1;
    endtask

    initial begin
        clear_inputs();
        i_Reset_N = 1'b0;
        repeat (2) step();
        #1;
        check("rst_grant", o_Grant, 2'b00);
        check("rst_arvalid", m_axil_arvalid, 0);
        check("rst_awvalid", m_axil_awvalid, 0);
        check("rst_wvalid", m_axil_wvalid, 0);
        check("rst_rready", m_axil_rready, 0);
        check("rst_bready", m_axil_bready, 0);
        check("rst_araddr", m_axil_araddr, 0);
        check("rst_instr_arready", s_instr_axil_arready, 0);
        check("rst_instr_rdata", s_instr_axil_rdata, 0);
        check("rst_data_bresp", s_data_axil_bresp, 0);
        i_Reset_N = 1'b1;
        // instr-only read, slave answers 3 cycles into the response phase
        step();
        s_instr_axil_arvalid = 1'b1;
        s_instr_axil_araddr = 32'h0000_0100;
        s_instr_axil_rready = 1'b1;
        #1;
        check("t1_arvalid_req_cycle", m_axil_arvalid, 0);
        step();
        check("t1_arvalid_next", m_axil_arvalid, 1);
        check("t1_grant", o_Grant, 2'b01);
        check("t1_araddr", m_axil_araddr, 32'h0000_0100);
        m_axil_arready = 1'b1;
        #1;
        check("t1_arready", s_instr_axil_arready, 1);
        step();
        s_instr_axil_arvalid = 1'b0;
        m_axil_arready = 1'b0;
        #1;
        check("t1_rready", m_axil_rready, 1);
        check("t1_rvalid_early", s_instr_axil_rvalid, 0);
        repeat (2) step();
        m_axil_rvalid = 1'b1;
        m_axil_rdata = 32'hDEAD_BEEF;
        #1;
        check("t1_rvalid", s_instr_axil_rvalid, 1);
        check("t1_rdata", s_instr_axil_rdata, 32'hDEAD_BEEF);
        check("t1_data_rvalid", s_data_axil_rvalid, 0);
        step();
        m_axil_rvalid = 1'b0;
        s_instr_axil_rready = 1'b0;
        #1;
        check("t1_idle_grant", o_Grant, 2'b00);
        // simultaneous instr and data reads right out of reset
        reset_pulse();
        s_instr_axil_arvalid = 1'b1;
        s_instr_axil_araddr = 32'h200;
        s_data_axil_arvalid = 1'b1;
        s_data_axil_araddr = 32'h300;
        s_instr_axil_rready = 1'b1;
        s_data_axil_rready = 1'b1;
        step();
        check("t2_grant_instr", o_Grant, 2'b01);
        check("t2_araddr_instr", m_axil_araddr, 32'h200);
        m_axil_arready = 1'b1;
        #1;
        check("t2_instr_arready", s_instr_axil_arready, 1);
        check("t2_data_arready_a", s_data_axil_arready, 0);
        step();
        s_instr_axil_arvalid = 1'b0;
        m_axil_arready = 1'b0;
        m_axil_rvalid = 1'b1;
        m_axil_rdata = 32'h1111_1111;
        #1;
        check("t2_data_arready_r", s_data_axil_arready, 0);
        check("t2_instr_rdata", s_instr_axil_rdata, 32'h1111_1111);
        check("t2_data_rvalid_a", s_data_axil_rvalid, 0);
        step();
        m_axil_rvalid = 1'b0;
        #1;
        check("t2_gap_grant", o_Grant, 2'b00);
        step();
        check("t2_grant_data", o_Grant, 2'b10);
        check("t2_araddr_data", m_axil_araddr, 32'h300);
        m_axil_arready = 1'b1;
        #1;
        check("t2_data_arready", s_data_axil_arready, 1);
        check("t2_instr_arready_0", s_instr_axil_arready, 0);
        step();
        s_data_axil_arvalid = 1'b0;
        m_axil_arready = 1'b0;
        m_axil_rvalid = 1'b1;
        m_axil_rdata = 32'h2222_2222;
        #1;
        check("t2_data_rdata", s_data_axil_rdata, 32'h2222_2222);
        check("t2_instr_rvalid_0", s_instr_axil_rvalid, 0);
        step();
        clear_inputs();
        // both ports requesting continuously: grants must alternate
        reset_pulse();
        s_instr_axil_arvalid = 1'b1;
        s_data_axil_arvalid = 1'b1;
        s_instr_axil_rready = 1'b1;
        s_data_axil_rready = 1'b1;
        m_axil_arready = 1'b1;
        m_axil_rvalid = 1'b1;
        m_axil_rdata = 32'h5A;
        for (int i = 0; i < 6; i++) begin
            step();
            check("t3_grant", o_Grant, (i % 2 == 0) ? 2'b01 : 2'b10);
            repeat (2) step();
            check("t3_gap", o_Grant, 2'b00);
        end
        clear_inputs();
        // data write, slave takes W two cycles before AW
        reset_pulse();
        s_data_axil_awvalid = 1'b1;
        s_data_axil_wvalid = 1'b1;
        s_data_axil_awaddr = 32'h400;
        s_data_axil_wdata = 32'h1234_5678;
        s_data_axil_wstrb = 4'hF;
        s_data_axil_bready = 1'b1;
        m_axil_wready = 1'b1;
        step();
        check("t4_grant", o_Grant, 2'b10);
        check("t4_awvalid", m_axil_awvalid, 1);
        check("t4_wvalid", m_axil_wvalid, 1);
        check("t4_wdata", m_axil_wdata, 32'h1234_5678);
        check("t4_wstrb", m_axil_wstrb, 4'hF);
        check("t4_awaddr", m_axil_awaddr, 32'h400);
        check("t4_data_wready", s_data_axil_wready, 1);
        check("t4_instr_wready", s_instr_axil_wready, 0);
        check("t4_data_awready_0", s_data_axil_awready, 0);
        step();
        s_data_axil_wvalid = 1'b0;
        m_axil_wready = 1'b0;
        #1;
        check("t4_wvalid_done", m_axil_wvalid, 0);
        check("t4_bready_early", m_axil_bready, 0);
        check("t4_grant_hold", o_Grant, 2'b10);
        step();
        m_axil_awready = 1'b1;
        #1;
        check("t4_data_awready", s_data_axil_awready, 1);
        step();
        s_data_axil_awvalid = 1'b0;
        m_axil_awready = 1'b0;
        m_axil_bvalid = 1'b1;
        m_axil_bresp = 2'b00;
        #1;
        check("t4_awvalid_resp", m_axil_awvalid, 0);
        check("t4_bready", m_axil_bready, 1);
        check("t4_data_bvalid", s_data_axil_bvalid, 1);
        check("t4_data_bresp", s_data_axil_bresp, 2'b00);
        check("t4_instr_bvalid", s_instr_axil_bvalid, 0);
        step();
        check("t4_idle_grant", o_Grant, 2'b00);
        check("t4_no_second_b", s_data_axil_bvalid, 0);
        m_axil_bvalid = 1'b0;
        // SLVERR passes through untouched, AW and W accepted together
        s_data_axil_awvalid = 1'b1;
        s_data_axil_wvalid = 1'b1;
        s_data_axil_awaddr = 32'h500;
        s_data_axil_wdata = 32'hCAFE_0001;
        m_axil_awready = 1'b1;
        m_axil_wready = 1'b1;
        step();
        check("t5_data_awready", s_data_axil_awready, 1);
        check("t5_data_wready", s_data_axil_wready, 1);
        step();
        s_data_axil_awvalid = 1'b0;
        s_data_axil_wvalid = 1'b0;
        m_axil_awready = 1'b0;
        m_axil_wready = 1'b0;
        m_axil_bvalid = 1'b1;
        m_axil_bresp = 2'b10;
        #1;
        check("t5_data_bvalid", s_data_axil_bvalid, 1);
        check("t5_data_bresp", s_data_axil_bresp, 2'b10);
        check("t5_instr_bresp", s_instr_axil_bresp, 2'b00);
        step();
        clear_inputs();
        // reset while waiting in the read response phase
        s_instr_axil_arvalid = 1'b1;
        s_instr_axil_araddr = 32'h600;
        s_instr_axil_rready = 1'b1;
        step();
        check("t6_grant", o_Grant, 2'b01);
        m_axil_arready = 1'b1;
        step();
        s_instr_axil_arvalid = 1'b0;
        m_axil_arready = 1'b0;
        m_axil_rvalid = 1'b1;
        m_axil_rdata = 32'h7777_7777;
        #1;
        check("t6_rvalid_pre", s_instr_axil_rvalid, 1);
        i_Reset_N = 1'b0;
        step();
        check("t6_rst_grant", o_Grant, 2'b00);
        check("t6_rst_rready", m_axil_rready, 0);
        check("t6_rst_rvalid", s_instr_axil_rvalid, 0);
        check("t6_rst_arvalid", m_axil_arvalid, 0);
        check("t6_rst_rdata", s_instr_axil_rdata, 0);
        i_Reset_N = 1'b1;
        m_axil_rvalid = 1'b0;
        s_instr_axil_arvalid = 1'b1;
        s_instr_axil_araddr = 32'h700;
        s_data_axil_arvalid = 1'b1;
        s_data_axil_araddr = 32'h800;
        step();
        check("t6_after_rst_grant", o_Grant, 2'b01);
        check("t6_after_rst_araddr", m_axil_araddr, 32'h700);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
